nds_async_fifo_rd_burst: RTL and testbench



---
 rtl/nds_async_fifo_rd_burst.sv | 133 +++++++++++++
 tb/tb_nds_async_fifo_rd_burst.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nds_async_fifo_rd_burst.sv
// Read-domain controller for the dual-clock async FIFO macro.
// It watches the FIFO empty/almost_empty flags, pops words into a 2-entry output
// buffer and presents them as a valid/ready stream with burst framing. Sparse
// arrivals wait for almost_empty to clear so they leave as BURST_LEN-beat bursts;
// a lone word that waits TIMEOUT cycles is flushed as a single-beat burst.
//
// Ports:
//   r_clk, r_reset_n   read-domain clock, asynchronous active-low reset
//   enable             1 = start new bursts; 0 = finish current burst, then idle
//   fifo_empty         FIFO empty flag
//   fifo_almost_empty  FIFO almost_empty flag
//   fifo_rd_data       FIFO head data, valid while !fifo_empty
//   fifo_rd            pop strobe to the FIFO
//   out_valid/ready    output stream handshake
//   out_data, out_last stream data and end-of-burst marker
//   busy               controller active or buffer holding data
module nds_async_fifo_rd_burst #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  r_clk,
  input  logic                  r_reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StFlush} state_e;

  state_e                           state_q;
  logic [BeatW-1:0]                 beat_cnt_q;
  logic [7:0]                       tmo_cnt_q;
  logic [1:0]                       buf_cnt_q;
  logic                             buf_wr_ptr_q;
  logic                             buf_rd_ptr_q;
  logic [1:0][DATA_WIDTH-1:0]       buf_data_q;
  logic [1:0]                       buf_last_q;

  logic space;
  logic pop;
  logic xfer;
  logic pop_last;

  // A full buffer still has room if the head leaves on this same edge.
  assign space    = (buf_cnt_q != 2'd2) | out_ready;
  assign pop      = ((state_q == StBurst) | (state_q == StFlush)) & ~fifo_empty & space;
  assign xfer     = out_valid & out_ready;
  assign pop_last = (state_q == StFlush) | (beat_cnt_q == BeatW'(BURST_LEN - 1));

  assign fifo_rd   = pop;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_data  = buf_data_q[buf_rd_ptr_q];
  assign out_last  = buf_last_q[buf_rd_ptr_q];
  assign busy      = (state_q != StIdle) | (buf_cnt_q != 2'd0);

  always_ff @(posedge r_clk or negedge r_reset_n) begin
    if (!r_reset_n) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      buf_cnt_q    <= '0;
      buf_wr_ptr_q <= 1'b0;
      buf_rd_ptr_q <= 1'b0;
      buf_data_q   <= '0;
      buf_last_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable & ~fifo_empty) begin
            if (fifo_almost_empty) begin
              state_q   <= StWait;
              tmo_cnt_q <= '0;
            end else begin
              state_q    <= StBurst;
              beat_cnt_q <= '0;
            end
          end
        end
        StWait: begin
          if (!enable) begin
            state_q <= StIdle;
          end else if (!fifo_almost_empty) begin
            state_q    <= StBurst;
            beat_cnt_q <= '0;
          end else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
            state_q <= StFlush;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        // An empty FIFO mid-burst simply stalls here; enable is not consulted.
        StBurst: begin
          if (pop) begin
            if (pop_last) begin
              state_q    <= StIdle;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + BeatW'(1);
            end
          end
        end
        StFlush: begin
          if (pop) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (pop) begin
        buf_data_q[buf_wr_ptr_q] <= fifo_rd_data;
        buf_last_q[buf_wr_ptr_q] <= pop_last;
        buf_wr_ptr_q             <= ~buf_wr_ptr_q;
      end
      if (xfer) buf_rd_ptr_q <= ~buf_rd_ptr_q;

      if (pop & ~xfer) begin
        buf_cnt_q <= buf_cnt_q + 2'd1;
      end else if (~pop & xfer) begin
        buf_cnt_q <= buf_cnt_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_nds_async_fifo_rd_burst.sv
// Bench for nds_async_fifo_rd_burst: a behavioural FIFO feeds the DUT, expected
// {last, data} beats are queued as words are released and compared as they leave.
module tb_nds_async_fifo_rd_burst;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int TO = 16;

  logic          r_clk = 1'b0;
  logic          r_reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          out_ready = 1'b0;
  logic          ae_force_low = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_almost_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic [DW-1:0] out_data;

  logic [DW-1:0] words[$];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   exp_beat;
  int unsigned   avail = 0;
  int unsigned   rd_idx = 0;
  int unsigned   nxt;
  int            n_total = 0;
  int            n_pass = 0;

  nds_async_fifo_rd_burst #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .r_clk            (r_clk),
    .r_reset_n        (r_reset_n),
    .enable           (enable),
    .fifo_empty       (fifo_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd          (fifo_rd),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: flags and head data update on the pop edge.
  always @(posedge r_clk) begin
    nxt = rd_idx + (fifo_rd ? 1 : 0);
    rd_idx <= nxt;
    fifo_empty <= (nxt >= avail);
    fifo_rd_data <= (nxt < avail) ? words[nxt] : '0;
    fifo_almost_empty <= ae_force_low ? 1'b0 : ((avail - nxt) < BL);
  end

  // Scoreboard and over-read monitor.
  always @(negedge r_clk) begin
    if (r_reset_n && out_valid && out_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_extra: got last=%0b data=%h, none expected", out_last, out_data);
      end else begin
        exp_beat = exp_q.pop_front();
        if ({out_last, out_data} !== exp_beat)
          $display("FAIL beat: got last=%0b data=%h, expected last=%0b data=%h",
                   out_last, out_data, exp_beat[DW], exp_beat[DW-1:0]);
        else n_pass++;
      end
    end
    if (fifo_rd) begin
      n_total++;
      if (fifo_empty !== 1'b0) $display("FAIL over_read: fifo_rd=1 with fifo_empty=%b", fifo_empty);
      else n_pass++;
    end
  end

  task automatic push_word(input logic [DW-1:0] w, input logic last, input bit track);
    words.push_back(w);
    avail++;
    if (track) exp_q.push_back({last, w});
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge r_clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    r_reset_n = 1'b0;
    enable = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge r_clk);
    n_total++; if (fifo_rd !== 1'b0) $display("FAIL rst_fifo_rd: got %b want 0", fifo_rd); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    @(posedge r_clk);
    #1 r_reset_n = 1'b1;
  endtask

  task automatic test_burst();
    int start, fall, first_rd, last_rd, first_v;
    logic busy_at_last;
    enable = 1'b1;
    out_ready = 1'b1;
    start = rd_idx;
    fall = -1; first_rd = -1; last_rd = -1; first_v = -1; busy_at_last = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hA0A0_0000 + 32'(i), (i == 3), 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge r_clk);
      if (!fifo_empty && fall < 0) fall = c;
      if (fifo_rd) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
      end
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_last) busy_at_last = busy;
    end
    n_total++; if (rd_idx - start != 4) $display("FAIL burst_pops: got %0d want 4", rd_idx - start); else n_pass++;
    n_total++; if (last_rd - first_rd != 3) $display("FAIL burst_consec: span %0d want 3", last_rd - first_rd); else n_pass++;
    n_total++; if (first_rd - fall != 1) $display("FAIL burst_rd_lat: got %0d want 1", first_rd - fall); else n_pass++;
    n_total++; if (first_v - fall != 2) $display("FAIL burst_valid_lat: got %0d want 2", first_v - fall); else n_pass++;
    n_total++; if (busy_at_last !== 1'b1) $display("FAIL burst_busy_last: got %b want 1", busy_at_last); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL burst_busy_end: got %b want 0", busy); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL burst_left: got %0d beats pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    int start, fall, first_rd, n_rd;
    enable = 1'b1;
    out_ready = 1'b1;
    start = rd_idx;
    fall = -1; first_rd = -1; n_rd = 0;
    push_word(32'hB0B0_0000, 1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge r_clk);
      if (!fifo_empty && fall < 0) fall = c;
      if (fifo_rd) begin
        if (first_rd < 0) first_rd = c;
        n_rd++;
      end
    end
    n_total++; if (first_rd - fall != TO + 1) $display("FAIL tmo_delay: got %0d want %0d", first_rd - fall, TO + 1); else n_pass++;
    n_total++; if (n_rd != 1) $display("FAIL tmo_rd_cycles: got %0d want 1", n_rd); else n_pass++;
    n_total++; if (rd_idx - start != 1) $display("FAIL tmo_pops: got %0d want 1", rd_idx - start); else n_pass++;
    n_total++; if (busy !== 1'b0 || exp_q.size() != 0) $display("FAIL tmo_end: busy=%b pending=%0d want 0/0", busy, exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int start;
    bit ok;
    enable = 1'b1;
    out_ready = 1'b0;
    start = rd_idx;
    for (int i = 0; i < 4; i++) push_word(32'hC0C0_0000 + 32'(i), (i == 3), 1'b1);
    repeat (15) @(negedge r_clk);
    n_total++; if (rd_idx - start != 2) $display("FAIL bp_pops: got %0d want 2", rd_idx - start); else n_pass++;
    n_total++; if (fifo_rd !== 1'b0) $display("FAIL bp_fifo_rd: got %b want 0", fifo_rd); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 32'hC0C0_0000) $display("FAIL bp_head: got %h want c0c00000", out_data); else n_pass++;
    repeat (3) @(negedge r_clk);
    n_total++; if ({out_last, out_data} !== {1'b0, 32'hC0C0_0000}) $display("FAIL bp_hold: got %b/%h want 0/c0c00000", out_last, out_data); else n_pass++;
    @(posedge r_clk);
    #1 out_ready = 1'b1;
    wait_drain(ok);
    n_total++; if (!ok) $display("FAIL bp_drain: got timeout want drained"); else n_pass++;
    n_total++; if (rd_idx - start != 4) $display("FAIL bp_total_pops: got %0d want 4", rd_idx - start); else n_pass++;
  endtask

  task automatic test_mid_empty();
    int start;
    bit ok;
    enable = 1'b1;
    out_ready = 1'b1;
    ae_force_low = 1'b1;
    start = rd_idx;
    push_word(32'hD0D0_0000, 1'b0, 1'b1);
    push_word(32'hD0D0_0001, 1'b0, 1'b1);
    repeat (14) @(negedge r_clk);
    n_total++; if (rd_idx - start != 2) $display("FAIL mid_pops: got %0d want 2", rd_idx - start); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL mid_beats: got %0d pending want 0", exp_q.size()); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_stall_busy: got %b want 1", busy); else n_pass++;
    @(posedge r_clk);
    #1;
    push_word(32'hD0D0_0002, 1'b0, 1'b1);
    push_word(32'hD0D0_0003, 1'b1, 1'b1);
    wait_drain(ok);
    n_total++; if (!ok) $display("FAIL mid_drain: got timeout want drained"); else n_pass++;
    n_total++; if (rd_idx - start != 4) $display("FAIL mid_total_pops: got %0d want 4", rd_idx - start); else n_pass++;
    ae_force_low = 1'b0;
  endtask

  task automatic test_enable_drop();
    int start;
    bit ok;
    enable = 1'b1;
    out_ready = 1'b1;
    start = rd_idx;
    push_word(32'hE0E0_0000, 1'b0, 1'b1);
    repeat (6) @(negedge r_clk);
    @(posedge r_clk);
    #1 enable = 1'b0;
    repeat (30) @(negedge r_clk);
    n_total++; if (rd_idx != start) $display("FAIL en_wait_pop: got %0d pops want 0", rd_idx - start); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL en_wait_idle: busy=%b want 0", busy); else n_pass++;
    for (int i = 1; i < 4; i++) push_word(32'hE0E0_0000 + 32'(i), (i == 3), 1'b1);
    @(posedge r_clk);
    #1 enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge r_clk);
      if (fifo_rd) break;
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hF0F0_0000 + 32'(i), (i == 3), 1'b1);
    repeat (20) @(negedge r_clk);
    n_total++; if (rd_idx - start != 4) $display("FAIL en_burst_pops: got %0d want 4", rd_idx - start); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL en_after_burst: busy=%b want 0", busy); else n_pass++;
    n_total++; if (fifo_empty !== 1'b0 || exp_q.size() != 4) $display("FAIL en_no_new: empty=%b pending=%0d want 0/4", fifo_empty, exp_q.size()); else n_pass++;
    @(posedge r_clk);
    #1 enable = 1'b1;
    wait_drain(ok);
    n_total++; if (!ok || rd_idx - start != 8) $display("FAIL en_resume: ok=%0b pops=%0d want 1/8", ok, rd_idx - start); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int start;
    bit ok;
    enable = 1'b1;
    out_ready = 1'b0;
    start = rd_idx;
    for (int i = 0; i < 4; i++) push_word(32'h9090_0000 + 32'(i), (i == 3), 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge r_clk);
      if (rd_idx - start >= 2) break;
    end
    repeat (2) @(negedge r_clk);
    push_word(32'h9090_0004, 1'b0, 1'b0);
    push_word(32'h9090_0005, 1'b0, 1'b0);
    #2 r_reset_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (fifo_rd !== 1'b0) $display("FAIL rmid_fifo_rd: got %b want 0", fifo_rd); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    // Popped beats are lost; the remaining words form a fresh 4-beat burst.
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h9090_0002});
    exp_q.push_back({1'b0, 32'h9090_0003});
    exp_q.push_back({1'b0, 32'h9090_0004});
    exp_q.push_back({1'b1, 32'h9090_0005});
    repeat (2) @(negedge r_clk);
    r_reset_n = 1'b1;
    out_ready = 1'b1;
    wait_drain(ok);
    n_total++; if (!ok) $display("FAIL rmid_drain: got timeout want drained"); else n_pass++;
    n_total++; if (rd_idx - start != 6) $display("FAIL rmid_pops: got %0d want 6", rd_idx - start); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_timeout();
    test_backpressure();
    test_mid_empty();
    test_enable_drop();
    test_reset_mid();
    repeat (2) @(negedge r_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at limit");
    $fatal(1, "watchdog expired");
  end

endmodule
